pipeline_hazard_ctrl: RTL

//  Hazard/forwarding controller for the 16-bit MIPS pipeline (IF, ID, EX, DM, WB).

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage 16-bit MIPS pipeline.
// Keeps an EX/DM/WB destination scoreboard and drives stalls, squashes, forward selects and WB write control.
module pipeline_hazard_ctrl #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             ex_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             wb_wr_en,
    output logic [RA_W-1:0]  wb_wr_addr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            wr;
    } slot_t;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t     state;
    state_t     state_next;
    slot_t      ex_slot;
    slot_t      dm_slot;
    slot_t      wb_slot;
    logic       ex_load;
    logic       load_use;
    logic       stall;
    logic       squash;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // r0 never carries a hazard: writes to it are discarded and reads return zero
    function automatic logic hits(input slot_t s, input logic [RA_W-1:0] r);
        return s.valid && s.wr && (s.rd != '0) && (s.rd == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [RA_W-1:0] r,
                                           input slot_t ex_s, input slot_t dm_s);
        if (!used)
            return 2'd0;
        else if (hits(ex_s, r))
            return 2'd1;
        else if (hits(dm_s, r))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        load_use = id_valid && ex_load &&
                   ((id_use_rs && hits(ex_slot, id_rs)) || (id_use_rt && hits(ex_slot, id_rt)));
        sel_a    = fwd_sel(id_use_rs, id_rs, ex_slot, dm_slot);
        sel_b    = fwd_sel(id_use_rt, id_rt, ex_slot, dm_slot);
    end

    // A taken branch squashes the ID instruction, so it overrides any load-use stall
    always_comb begin
        state_next = RUN;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        stall      = 1'b0;
        squash     = 1'b0;
        if (ex_br_taken) begin
            squash     = 1'b1;
            ifid_flush = 1'b1;
            state_next = FLUSH;
        end else if (state != STALL && load_use) begin
            stall      = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            state_next = STALL;
        end
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ex_slot   <= '0;
            dm_slot   <= '0;
            wb_slot   <= '0;
            ex_load   <= 1'b0;
            fwd_a_sel <= 2'd0;
            fwd_b_sel <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_next;
            dm_slot <= ex_slot;
            wb_slot <= dm_slot;
            if (stall || squash || !id_valid) begin
                ex_slot   <= '0;
                ex_load   <= 1'b0;
                fwd_a_sel <= 2'd0;
                fwd_b_sel <= 2'd0;
            end else begin
                ex_slot   <= '{valid: 1'b1, rd: id_rd, wr: id_wr};
                ex_load   <= id_load;
                fwd_a_sel <= sel_a;
                fwd_b_sel <= sel_b;
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (squash && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign wb_wr_en   = wb_slot.valid && wb_slot.wr && (wb_slot.rd != '0);
    assign wb_wr_addr = wb_slot.rd;

endmodule
